key_schedule_reverse: RTL and testbench
=======================================

// Module: key_schedule_reverse
// PURPOSE
//  Inverse SIMON32/64 key schedule for the decryption datapath.
//  - Loads the last four round keys {k31,k30,k29,k28}.
//  - Streams all 32 round keys in reverse order, k31 down to k0, one per accepted handshake.
//  - Runs each inverse step on the fly, so no 32-entry key RAM is needed.
//  - Feeds the iterative decryption round, which consumes keys in descending round order.
// PARAMETERS
//  N_ROUNDS  32  number of round keys streamed; only 32 (SIMON32/64) is supported and verified
// PORTS
//  clk        in   1   single clock; all logic on rising edge
//  rst_n      in   1   reset, asynchronous assert, active-low
//  start      in   1   load request; sampled only in IDLE
//  last_keys  in   64  {k31,k30,k29,k28}; k31 in [63:48]
//  busy       out  1   high from cycle after start accepted until final key accepted
//  key_valid  out  1   round_key/round_idx valid
//  key_ready  in   1   consumer accepts key when key_valid && key_ready
//  round_key  out  16  current round key k[round_idx]
//  round_idx  out  5   index of round_key, 31 down to 0
//  done       out  1   one-cycle pulse after k0 accepted
// BEHAVIOUR
//  - Reset (rst_n low, async): state=IDLE, window=0, round_idx=0.
//    busy=0, key_valid=0, done=0, round_key=0.
//  - Reset mid-stream aborts immediately; no done pulse is issued.
//  - States:
//    IDLE -> RUN when start=1: window <= last_keys, round_idx <= 31.
//    RUN  -> IDLE when a handshake occurs with round_idx==0; done=1 for one cycle.
//  - Latency: start in cycle T -> key_valid=1 with k31, idx 31 in cycle T+1.
//  - Throughput: one key per cycle while key_ready=1.
//  - Window w[3:0] = {k[j],k[j-1],k[j-2],k[j-3]}, j=round_idx; round_key = w[3].
//  - On handshake:
//    w <= {w[2],w[1],w[0],knew}; round_idx <= j-1.
//    knew = k[j-4] = w[3] ^ C ^ Z0[j-4] ^ t ^ ror1(t), with t = ror3(w[2]) ^ w[0].
//    C = 16'hFFFC; Z0[j-4] enters at bit 0 only.
//    For j<4, knew = 0 (never output).
//  - Backpressure: while key_valid && !key_ready, round_key, round_idx and window hold stable.
//  - start while busy is ignored, including in the final-handshake cycle.
//  - start is accepted in the IDLE cycle coinciding with done; a new stream begins next cycle.
//  - last_keys is sampled only on the accepting edge; later changes have no effect.
//  - All arithmetic is 16-bit XOR and rotation; rotates are circular, with no carries.
// STRUCTURE
//  - simon_pkg (shared package):
//    typedef logic [15:0] key_word_t;
//    localparam Z0 (62-bit, bit i = z0 sequence element i);
//    localparam C = 16'hFFFC;
//    N_WORDS = 4.
//  - Sub-module key_step_inv: combinational
//    (k_i4, k_i3, k_i1, z_bit) -> k_i.
//    It is the exact inverse of the forward step; the top holds the FSM, window and counter.
// TESTING
//  - Golden: run forward step x28 on key 1918_1110_0908_0100 to get k28..k31.
//    Load them, hold key_ready=1. Expect 32 keys on consecutive cycles,
//    idx 31..0, final four 0x1918, 0x1110, 0x0908, 0x0100; done one cycle after.
//  - Backpressure: drop key_ready for 3 cycles at idx 20.
//    round_key/idx must hold; the sequence must equal the golden stream.
//  - Start while busy: pulse start at idx 15 with different last_keys.
//    The stream is unchanged; busy stays high.
//  - Back-to-back: assert start in the done cycle.
//    The next stream's k31 appears the following cycle; no gap in idx restart.
//  - Reset mid-stream: deassert rst_n at idx 10.
//    All outputs 0 asynchronously, no done pulse; a restart gives the full golden stream.
//  - Randomized keys (1000): forward-generate, reverse-stream with random key_ready.
//    Compare all 32 keys against the forward model.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared SIMON32/64 key-schedule types, constants and rotate helpers.
package simon_pkg;

    localparam int unsigned KEY_W   = 16;
    localparam int unsigned N_WORDS = 4;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned Z_LEN   = 62;

    typedef logic [KEY_W-1:0] key_word_t;
    typedef logic [N_WORDS-1:0][KEY_W-1:0] window_t;

    localparam key_word_t C = 16'hFFFC;

    // z0 written as published, element 0 leftmost; one period is 31 bits
    localparam logic [Z_LEN-1:0] Z0_SEQ = {2{31'b1111101000100101011000011100110}};

    function automatic logic [Z_LEN-1:0] rev_z(input logic [Z_LEN-1:0] x);
        logic [Z_LEN-1:0] r;
        for (int i = 0; i < int'(Z_LEN); i++) begin
            r[i] = x[Z_LEN-1-i];
        end
        return r;
    endfunction

    // Bit i holds sequence element i
    localparam logic [Z_LEN-1:0] Z0 = rev_z(Z0_SEQ);

    function automatic key_word_t ror1(input key_word_t x);
        return {x[0], x[KEY_W-1:1]};
    endfunction

    function automatic key_word_t ror3(input key_word_t x);
        return {x[2:0], x[KEY_W-1:3]};
    endfunction

endpackage

// File: rtl/key_step_inv.sv
// One inverse key-schedule step: recovers k[i] from k[i+4], k[i+3], k[i+1] and z0[i].
module key_step_inv
    import simon_pkg::*;
(
    input  key_word_t k_i4,
    input  key_word_t k_i3,
    input  key_word_t k_i1,
    input  logic      z_bit,
    output key_word_t k_i
);

    key_word_t t;

    assign t   = ror3(k_i3) ^ k_i1;
    assign k_i = k_i4 ^ C ^ {{(KEY_W-1){1'b0}}, z_bit} ^ t ^ ror1(t);

endmodule

// File: rtl/key_schedule_reverse.sv
// Streams SIMON32/64 round keys k31..k0, regenerating each older key from a 4-word window.
module key_schedule_reverse
    import simon_pkg::*;
#(
    parameter int unsigned N_ROUNDS = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [63:0]      last_keys,
    output logic             busy,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [15:0]      round_key,
    output logic [4:0]       round_idx,
    output logic             done
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state, state_d;
    window_t          window, window_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_d, done_d;
    logic [5:0]       z_idx_c;
    logic             z_bit_c;
    logic             has_older_c;
    key_word_t        key_new_c, key_in_c;

    // Window order: [3]=k[j], [2]=k[j-1], [1]=k[j-2], [0]=k[j-3]
    assign has_older_c = (idx_q >= IDX_W'(N_WORDS));
    assign z_idx_c     = 6'(idx_q) - 6'(N_WORDS);
    assign z_bit_c     = has_older_c ? Z0[z_idx_c] : 1'b0;

    key_step_inv u_step (
        .k_i4  (window[3]),
        .k_i3  (window[2]),
        .k_i1  (window[0]),
        .z_bit (z_bit_c),
        .k_i   (key_new_c)
    );

    // Keys below k0 are never presented, so shift in zeros
    assign key_in_c = has_older_c ? key_new_c : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        window_d = window;
        idx_d    = idx_q;
        done_d   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    window_d = last_keys;
                    idx_d    = IDX_W'(N_ROUNDS - 1);
                end
            end
            S_RUN: begin
                if (key_ready) begin
                    window_d = {window[N_WORDS-2:0], key_in_c};
                    if (idx_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window    <= '0;
            idx_q     <= '0;
            busy      <= 1'b0;
            key_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            window    <= window_d;
            idx_q     <= idx_d;
            busy      <= busy_d;
            key_valid <= busy_d;
            done      <= done_d;
        end
    end

    assign round_key = window[N_WORDS-1];
    assign round_idx = idx_q;

endmodule

// File: tb/tb_key_schedule_reverse.sv
// Scoreboard bench for key_schedule_reverse against a forward SIMON32/64 key-expansion model.
module tb_key_schedule_reverse;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] last_keys;
    logic        busy;
    logic        key_valid;
    logic        key_ready;
    logic [15:0] round_key;
    logic [4:0]  round_idx;
    logic        done;

    key_schedule_reverse dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .last_keys (last_keys),
        .busy      (busy),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [61:0] zseq;
    logic [15:0] ks [32];
    logic [15:0] cap [32];
    logic [20:0] sb_q [$];
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rotr(input logic [15:0] x, input int n);
        return (x >> n) | (x << (16 - n));
    endfunction

    // Forward expansion of a 64-bit key {k3,k2,k1,k0} into ks[0..31]
    task automatic expand(input logic [63:0] key);
        logic [15:0] tmp;
        ks[0] = key[15:0];
        ks[1] = key[31:16];
        ks[2] = key[47:32];
        ks[3] = key[63:48];
        for (int i = 4; i < 32; i++) begin
            tmp = rotr(ks[i-1], 3) ^ ks[i-3];
            tmp = tmp ^ rotr(tmp, 1);
            ks[i] = ~ks[i-4] ^ tmp ^ {15'd0, zseq[61-(i-4)]} ^ 16'd3;
        end
    endtask

    function automatic logic [63:0] tail_keys();
        return {ks[31], ks[30], ks[29], ks[28]};
    endfunction

    // One clock: check outputs at the falling edge, then drive inputs and advance the model
    task automatic cycle(input logic st, input logic rdy, input logic [63:0] lk);
        logic [20:0] e;
        logic        nxt_done;
        @(negedge clk);
        check_eq("busy", 32'(busy), 32'(exp_busy));
        check_eq("key_valid", 32'(key_valid), 32'(exp_busy));
        check_eq("done", 32'(done), 32'(exp_done));
        e = (sb_q.size() > 0) ? sb_q[0] : '1;
        if (exp_busy) begin
            check_eq("round_idx", 32'(round_idx), 32'(e[20:16]));
            check_eq("round_key", 32'(round_key), 32'(e[15:0]));
        end
        start     = st;
        key_ready = rdy;
        last_keys = lk;
        nxt_done  = 1'b0;
        if (exp_busy) begin
            if (rdy && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cap[e[20:16]] = round_key;
                if (e[20:16] == 5'd0) begin
                    exp_busy = 1'b0;
                    nxt_done = 1'b1;
                end
            end
        end else if (st) begin
            for (int i = 31; i >= 0; i--) sb_q.push_back({5'(i), ks[i]});
            exp_busy = 1'b1;
        end
        exp_done = nxt_done;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(key_valid), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_key", 32'(round_key), 32'd0);
        check_eq("rst_idx", 32'(round_idx), 32'd0);
        sb_q.delete();
        exp_busy = 1'b0;
        exp_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // mode 0 ready, 1 stall at idx 20, 2 start at idx 15, 3 random ready, 5 reset at idx 10
    task automatic run_stream(input int mode);
        logic [63:0] lk;
        logic [4:0]  cur;
        int          guard;
        int          stall;
        logic        poked;
        lk    = tail_keys();
        guard = 0;
        stall = 0;
        poked = 1'b0;
        cycle(1'b1, 1'b1, lk);
        while (exp_busy && guard < 400) begin
            guard++;
            cur = (sb_q.size() > 0) ? sb_q[0][20:16] : 5'd0;
            if (mode == 1 && cur == 5'd20 && stall < 3) begin
                stall++;
                cycle(1'b0, 1'b0, lk);
            end else if (mode == 2 && cur == 5'd15 && !poked) begin
                poked = 1'b1;
                cycle(1'b1, 1'b1, ~lk);
            end else if (mode == 3) begin
                cycle(1'b0, $urandom_range(0, 3) != 0, lk);
            end else if (mode == 5 && cur == 5'd10) begin
                do_reset();
                break;
            end else begin
                cycle(1'b0, 1'b1, lk);
            end
        end
        if (guard >= 400) check_eq("timeout", 32'(exp_busy), 32'd0);
    endtask

    initial begin
        zseq      = {2{31'b1111101000100101011000011100110}};
        rst_n     = 1'b0;
        start     = 1'b0;
        key_ready = 1'b0;
        last_keys = '0;
        #3;
        check_eq("init_busy", 32'(busy), 32'd0);
        check_eq("init_valid", 32'(key_valid), 32'd0);
        check_eq("init_done", 32'(done), 32'd0);
        check_eq("init_key", 32'(round_key), 32'd0);
        check_eq("init_idx", 32'(round_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Golden vector, full-rate consumer
        expand(64'h1918_1110_0908_0100);
        for (int i = 0; i < 32; i++) cap[i] = 16'hDEAD;
        run_stream(0);
        idle(3);
        check_eq("gold_k3", 32'(cap[3]), 32'h1918);
        check_eq("gold_k2", 32'(cap[2]), 32'h1110);
        check_eq("gold_k1", 32'(cap[1]), 32'h0908);
        check_eq("gold_k0", 32'(cap[0]), 32'h0100);

        run_stream(1);
        idle(2);
        run_stream(2);
        idle(2);

        // Back-to-back: second start lands in the done cycle
        run_stream(0);
        expand(64'h0123_4567_89AB_CDEF);
        run_stream(0);
        idle(2);

        expand(64'h1918_1110_0908_0100);
        run_stream(5);
        idle(3);
        run_stream(0);
        idle(2);

        for (int n = 0; n < 1000; n++) begin
            expand({$urandom, $urandom});
            run_stream(3);
            if ($urandom_range(0, 1) == 0) idle(1);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
